frame_stream_reader: RTL and testbench

Reads one greyscale frame from a synchronous-read image memory in raster order and transmits it as a valid/ready pixel stream into `convolution_filter`'s `x_*` input. It replaces bench-driven pixel streaming in hardware and sits between the frame buffer and the filtering pipeline. It sustains one pixel per cycle under no backpressure, absorbs the memory's 1-cycle read latency, and never drops or duplicates pixels under arbitrary `y_ready`.

---
 rtl/image_pkg.sv | 18 +
 rtl/stream_skid_fifo.sv | 53 +++++
 rtl/frame_stream_reader.sv | 128 ++++++++++++
 tb/tb_frame_stream_reader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared image-stream types and default frame geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package image_pkg;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int DEF_PIX_W      = 8;

  typedef logic [DEF_PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// 2-entry valid/ready FIFO with fall-through when empty.
// Latency: 0 cycles when empty (input bypasses to output), else head-of-queue.
// Backpressure: in_rdy_o drops only when both entries are occupied.
module stream_skid_fifo #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld_i,
  input  logic [DW-1:0] in_dat_i,
  output logic          in_rdy_o,
  output logic          out_vld_o,
  output logic [DW-1:0] out_dat_o,
  input  logic          out_rdy_i,
  output logic [1:0]    count_o
);

  logic [DW-1:0] mem_q [2];
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          empty, store, unload, wr_ptr;

  // Bypass the input straight to the output when empty; store only what is not consumed.
  always_comb begin
    empty     = (cnt_q == 2'd0);
    in_rdy_o  = (cnt_q != 2'd2);
    out_vld_o = !empty || in_vld_i;
    out_dat_o = '0;
    if (!empty)        out_dat_o = mem_q[rd_ptr_q];
    else if (in_vld_i) out_dat_o = in_dat_i;
    unload    = !empty && out_rdy_i;
    store     = in_vld_i && in_rdy_o && !(empty && out_rdy_i);
    wr_ptr    = rd_ptr_q ^ cnt_q[0];
    rd_ptr_d  = unload ? ~rd_ptr_q : rd_ptr_q;
    cnt_d     = cnt_q + {1'b0, store} - {1'b0, unload};
    count_o   = cnt_q;
  end

  // Storage, read pointer and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (store) mem_q[wr_ptr] <= in_dat_i;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_stream_reader.sv
// Streams one frame from a 1-cycle-latency memory as a raster-order valid/ready pixel stream.
// Latency: start at edge k -> first read in cycle k+1, first pixel valid in cycle k+2.
// Backpressure: reads issue only while buffered + in-flight < 2, so stalls hold within one cycle.
import image_pkg::*;

module frame_stream_reader #(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int W          = DEF_PIX_W,
  parameter int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [W-1:0]      mem_rd_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [W-1:0]      y_data,
  output logic              y_sof,
  output logic              y_eol
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              inflight_q, sof_q, eol_q, done_q;
  logic              rd_en, last_col, last_row, final_hs;
  logic              fifo_in_rdy;
  logic [1:0]        fifo_cnt;
  logic [W+1:0]      fifo_out;

  assign last_col = (col_q == COL_W'(IMG_WIDTH - 1));
  assign last_row = (row_q == ROW_W'(IMG_HEIGHT - 1));
  // The last pixel leaves when exactly one entry (buffered or in flight) remains.
  assign final_hs = (state_q == DRAIN) && y_valid && y_ready &&
                    ((fifo_cnt + {1'b0, inflight_q}) == 2'd1);

  // Next state, read issue and raster counters.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      STREAM: begin
        rd_en = fifo_in_rdy && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && !inflight_q));
        if (rd_en) begin
          if (last_col && last_row) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (last_col) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (final_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, in-flight read tags and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      inflight_q <= rd_en;
      sof_q      <= (addr_q == '0);
      eol_q      <= last_col;
      done_q     <= final_hs;
    end
  end

  stream_skid_fifo #(.DW(W + 2)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld_i  (inflight_q),
    .in_dat_i  ({mem_rd_data, sof_q, eol_q}),
    .in_rdy_o  (fifo_in_rdy),
    .out_vld_o (y_valid),
    .out_dat_o (fifo_out),
    .out_rdy_i (y_ready),
    .count_o   (fifo_cnt)
  );

  assign y_data    = fifo_out[W+1:2];
  assign y_sof     = y_valid && fifo_out[1];
  assign y_eol     = y_valid && fifo_out[0];
  assign mem_rd_en = rd_en;
  assign mem_addr  = addr_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_frame_stream_reader.sv
module tb_frame_stream_reader;

  localparam int IW = 4;
  localparam int IH = 3;
  localparam int NP = IW * IH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       y_ready = 1'b0;
  logic [7:0] mem_rd_data = 8'h00;
  logic       busy, done, mem_rd_en, y_valid, y_sof, y_eol;
  logic [3:0] mem_addr;
  logic [7:0] y_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  frame_stream_reader #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_sof(y_sof), .y_eol(y_eol)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Synchronous-read image memory preloaded with mem[i] = i + 0x10.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= 8'h10 + {4'h0, mem_addr};

  // Observation log, sampled at the falling edge.
  logic [9:0] hs_q[$];
  int         hs_cyc[$];
  int         done_cyc[$];
  int         rd_cyc[$];
  int         viol_out = 0, viol_stab = 0, issued = 0, handshaked = 0;
  bit         prev_stall = 0;
  logic [9:0] prev_pl = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      issued = 0; handshaked = 0; prev_stall = 0;
    end else begin
      if (mem_rd_en) begin issued++; rd_cyc.push_back(cyc); end
      if (issued - handshaked > 2) viol_out++;
      if (prev_stall && (!y_valid || {y_data, y_sof, y_eol} !== prev_pl)) viol_stab++;
      prev_stall = y_valid && !y_ready;
      prev_pl = {y_data, y_sof, y_eol};
      if (y_valid && y_ready) begin
        hs_q.push_back({y_data, y_sof, y_eol});
        hs_cyc.push_back(cyc);
        handshaked++;
      end
      if (done) done_cyc.push_back(cyc);
    end
  end

  // Counts deviations of the frame logged from index base against the expected raster.
  function automatic int frame_errs(int base, int k, bit chk_cyc);
    int e = 0;
    logic [9:0] exp;
    if (hs_q.size() - base < NP) return 100;
    for (int i = 0; i < NP; i++) begin
      exp = {8'(16 + i), 1'(i == 0), 1'(i % IW == IW - 1)};
      if (hs_q[base + i] !== exp) e++;
      if (chk_cyc && hs_cyc[base + i] != k + 2 + i) e++;
    end
    return e;
  endfunction

  task automatic do_start(output int k);
    @(posedge clk); #2;
    start = 1'b1;
    k = cyc;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int nd_before, input int budget, input bit rnd, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (rnd) y_ready = 1'($urandom_range(0, 1));
      if (done_cyc.size() > nd_before) begin ok = 1; break; end
    end
    y_ready = 1'b1;
  endtask

  task automatic test_reset();
    int idle_err = 0;
    rst_n = 1'b0; start = 1'b0; y_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, mem_rd_en, mem_addr, y_valid, y_data, y_sof, y_eol} !== 18'h0) begin
      n_bad++;
      $display("FAIL reset_values got %h want 0",
               {busy, done, mem_rd_en, mem_addr, y_valid, y_data, y_sof, y_eol});
    end
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (y_valid || mem_rd_en || busy || done) idle_err++;
    end
    n_cmp++;
    if (idle_err != 0) begin n_bad++; $display("FAIL idle_no_output got %0d want 0", idle_err); end
  endtask

  task automatic test_full_rate();
    int k, hb, db, rb;
    bit ok;
    logic [9:0] exp;
    y_ready = 1'b1;
    hb = hs_q.size(); db = done_cyc.size(); rb = rd_cyc.size();
    do_start(k);
    wait_done(db, 100, 0, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL full_timeout got no done want done"); end
    n_cmp++;
    if (rd_cyc.size() <= rb || rd_cyc[rb] != k + 1) begin
      n_bad++; $display("FAIL first_read_cycle got %0d want %0d",
                        (rd_cyc.size() > rb) ? rd_cyc[rb] - k : -1, 1);
    end
    n_cmp++;
    if (hs_q.size() - hb != NP) begin
      n_bad++; $display("FAIL full_count got %0d want %0d", hs_q.size() - hb, NP);
    end
    for (int i = 0; i < NP && hb + i < hs_q.size(); i++) begin
      exp = {8'(16 + i), 1'(i == 0), 1'(i % IW == IW - 1)};
      n_cmp++;
      if (hs_q[hb + i] !== exp) begin
        n_bad++; $display("FAIL full_pix%0d got %h want %h", i, hs_q[hb + i], exp);
      end
      n_cmp++;
      if (hs_cyc[hb + i] != k + 2 + i) begin
        n_bad++; $display("FAIL full_cyc%0d got k+%0d want k+%0d", i, hs_cyc[hb + i] - k, 2 + i);
      end
    end
    n_cmp++;
    if (done_cyc.size() <= db || done_cyc[db] != k + NP + 2) begin
      n_bad++; $display("FAIL full_done_cycle got k+%0d want k+%0d",
                        (done_cyc.size() > db) ? done_cyc[db] - k : -1, NP + 2);
    end
  endtask

  task automatic test_backpressure();
    int k, hb, db, vo, vs, fe;
    bit ok;
    y_ready = 1'b0;
    hb = hs_q.size(); db = done_cyc.size(); vo = viol_out; vs = viol_stab;
    do_start(k);
    wait_done(db, 400, 1, ok);
    repeat (5) @(posedge clk);
    #2;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL bp_timeout got no done want done"); end
    fe = frame_errs(hb, k, 0);
    n_cmp++;
    if (fe != 0 || hs_q.size() - hb != NP) begin
      n_bad++; $display("FAIL bp_sequence got %0d errs %0d pix want 0 errs %0d pix", fe, hs_q.size() - hb, NP);
    end
    n_cmp++;
    if (viol_out != vo) begin n_bad++; $display("FAIL bp_outstanding got %0d want 0", viol_out - vo); end
    n_cmp++;
    if (viol_stab != vs) begin n_bad++; $display("FAIL bp_stable got %0d want 0", viol_stab - vs); end
    n_cmp++;
    if (done_cyc.size() - db != 1) begin
      n_bad++; $display("FAIL bp_done_count got %0d want 1", done_cyc.size() - db);
    end
  endtask

  task automatic test_hold();
    int k, hb, db, fv, hold_err, rd_err, fe;
    bit ok;
    y_ready = 1'b0;
    hb = hs_q.size(); db = done_cyc.size();
    do_start(k);
    fv = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (y_valid) begin fv = cyc; break; end
    end
    n_cmp++;
    if (fv != k + 2) begin n_bad++; $display("FAIL hold_first_valid got k+%0d want k+2", fv - k); end
    hold_err = 0; rd_err = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!y_valid || y_data !== 8'h10 || y_sof !== 1'b1) hold_err++;
      if (mem_rd_en) rd_err++;
    end
    n_cmp++;
    if (hold_err != 0) begin n_bad++; $display("FAIL hold_data got %0d bad cycles want 0", hold_err); end
    n_cmp++;
    if (rd_err != 0) begin n_bad++; $display("FAIL hold_rd_en got %0d read cycles want 0", rd_err); end
    @(posedge clk); #2; y_ready = 1'b1;
    wait_done(db, 100, 0, ok);
    fe = frame_errs(hb, k, 0);
    n_cmp++;
    if (!ok || fe != 0) begin n_bad++; $display("FAIL hold_resume got %0d errs want 0", fe); end
    n_cmp++;
    if (hs_q.size() - hb < NP || hs_cyc[hb + NP - 1] - hs_cyc[hb] != NP - 1) begin
      n_bad++; $display("FAIL hold_full_rate got span %0d want %0d",
                        (hs_q.size() - hb >= NP) ? hs_cyc[hb + NP - 1] - hs_cyc[hb] : -1, NP - 1);
    end
  endtask

  task automatic test_restart_ignored();
    int k, hb, db, rb, fe;
    bit ok;
    y_ready = 1'b1;
    hb = hs_q.size(); db = done_cyc.size(); rb = rd_cyc.size();
    do_start(k);
    repeat (4) @(posedge clk);
    #2; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    wait_done(db, 100, 0, ok);
    repeat (30) @(posedge clk);
    #2;
    fe = frame_errs(hb, k, 1);
    n_cmp++;
    if (!ok || fe != 0 || hs_q.size() - hb != NP) begin
      n_bad++; $display("FAIL restart_pixels got %0d pix %0d errs want %0d pix 0 errs", hs_q.size() - hb, fe, NP);
    end
    n_cmp++;
    if (done_cyc.size() - db != 1) begin
      n_bad++; $display("FAIL restart_done_count got %0d want 1", done_cyc.size() - db);
    end
    n_cmp++;
    if (rd_cyc.size() - rb != NP) begin
      n_bad++; $display("FAIL restart_reads got %0d want %0d", rd_cyc.size() - rb, NP);
    end
  endtask

  task automatic test_reset_mid();
    int k, hb, db, fe, idle_err;
    bit ok;
    y_ready = 1'b1;
    hb = hs_q.size(); db = done_cyc.size();
    do_start(k);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (hs_q.size() - hb >= 5) break;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, mem_rd_en, mem_addr, y_valid, y_data, y_sof, y_eol} !== 18'h0) begin
      n_bad++;
      $display("FAIL midreset_values got %h want 0",
               {busy, done, mem_rd_en, mem_addr, y_valid, y_data, y_sof, y_eol});
    end
    n_cmp++;
    if (hs_q.size() - hb != 5) begin n_bad++; $display("FAIL midreset_pix got %0d want 5", hs_q.size() - hb); end
    repeat (2) @(negedge clk);
    @(posedge clk); #2; rst_n = 1'b1;
    idle_err = 0;
    repeat (5) begin
      @(negedge clk);
      if (y_valid || mem_rd_en || busy || done) idle_err++;
    end
    n_cmp++;
    if (idle_err != 0 || done_cyc.size() != db) begin
      n_bad++; $display("FAIL midreset_quiet got %0d active %0d done want 0 0", idle_err, done_cyc.size() - db);
    end
    hb = hs_q.size(); db = done_cyc.size();
    do_start(k);
    wait_done(db, 100, 0, ok);
    fe = frame_errs(hb, k, 1);
    n_cmp++;
    if (!ok || fe != 0) begin n_bad++; $display("FAIL midreset_restream got %0d errs want 0", fe); end
  endtask

  task automatic test_back_to_back();
    int k1, dc, hb, db, low, fe1, fe2;
    bit ok;
    y_ready = 1'b1;
    hb = hs_q.size(); db = done_cyc.size();
    do_start(k1);
    dc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin dc = cyc; break; end
    end
    n_cmp++;
    if (dc != k1 + NP + 2 || busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_done1 got k+%0d busy=%b want k+%0d busy=0", dc - k1, busy, NP + 2);
    end
    start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    low = 0;
    for (int i = 0; i < NP + 1; i++) begin
      @(negedge clk);
      if (!busy) low++;
    end
    n_cmp++;
    if (low != 0) begin n_bad++; $display("FAIL b2b_busy got %0d low cycles want 0", low); end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_done2 got done=%b busy=%b want done=1 busy=0", done, busy);
    end
    @(posedge clk); #2;
    fe1 = frame_errs(hb, k1, 1);
    fe2 = frame_errs(hb + NP, dc, 1);
    n_cmp++;
    if (fe1 != 0 || fe2 != 0 || done_cyc.size() - db != 2) begin
      n_bad++; $display("FAIL b2b_frames got %0d/%0d errs %0d dones want 0/0 2", fe1, fe2, done_cyc.size() - db);
    end
    ok = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_hold();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
